// File: rtl/vga_text_pkg.sv
// Shared constants, state encoding and cell-layout helper for the text buffer.
package vga_text_pkg;

  localparam int COLS = 12;
  localparam int ROWS = 13;

  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_C     = 7'h43;
  localparam logic [6:0] ASCII_H     = 7'h48;
  localparam logic [6:0] ASCII_DOT   = 7'h2E;
  localparam logic [6:0] ASCII_V     = 7'h56;
  localparam logic [6:0] ASCII_0     = 7'h30;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_CONVERT = 2'd2,
    ST_WRITE   = 2'd3
  } state_t;

  // Character for one cell of row "CHrr d.dddV "; bcd holds the mV digits d3..d0.
  function automatic logic [6:0] cell_char(input logic [3:0]  row,
                                           input logic [3:0]  col,
                                           input logic [15:0] bcd);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = (row >= 4'd10) ? 4'd1 : 4'd0;
    units = (row >= 4'd10) ? row - 4'd10 : row;
    case (col)
      4'd0:    cell_char = ASCII_C;
      4'd1:    cell_char = ASCII_H;
      4'd2:    cell_char = ASCII_0 + {3'b000, tens};
      4'd3:    cell_char = ASCII_0 + {3'b000, units};
      4'd5:    cell_char = ASCII_0 + {3'b000, bcd[15:12]};
      4'd6:    cell_char = ASCII_DOT;
      4'd7:    cell_char = ASCII_0 + {3'b000, bcd[11:8]};
      4'd8:    cell_char = ASCII_0 + {3'b000, bcd[7:4]};
      4'd9:    cell_char = ASCII_0 + {3'b000, bcd[3:0]};
      4'd10:   cell_char = ASCII_V;
      default: cell_char = ASCII_SPACE;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 12-bit binary to 4 BCD digits, one bit per clock.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] bin,
  output logic [15:0] bcd,
  output logic        done
);

  logic [11:0] sh_bin;
  logic [3:0]  cnt;
  logic        busy;
  logic [15:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd    <= '0;
      sh_bin <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      bcd    <= '0;
      sh_bin <= bin;
      cnt    <= 4'd12;
      busy   <= 1'b1;
    end else if (busy) begin
      bcd    <= {adj[14:0], sh_bin[11]};
      sh_bin <= {sh_bin[10:0], 1'b0};
      cnt    <= cnt - 4'd1;
      if (cnt == 4'd1) busy <= 1'b0;
    end
  end

  // High during the final iteration so the consumer can advance on the same edge.
  assign done = busy && (cnt == 4'd1);

endmodule

// File: rtl/vga_text_buffer.sv
// Character RAM for the measurement display; rewrites one row per incoming
// channel voltage and serves the character renderer with 1-cycle reads.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_INIT    | write template "CHrr 0.000V " to all cells, one per cycle
// ST_IDLE    | meas_ready=1, wait for a measurement
// ST_CONVERT | double-dabble running on the captured value (12 cycles)
// ST_WRITE   | write the 12 cells of the captured row (12 cycles)
module vga_text_buffer #(
  parameter int COLS = vga_text_pkg::COLS,
  parameter int ROWS = vga_text_pkg::ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] meas_data,
  input  logic [3:0]  meas_ch,
  input  logic        meas_valid,
  output logic        meas_ready,
  input  logic [7:0]  text_xy,
  output logic [6:0]  char_code
);

  import vga_text_pkg::*;

  localparam logic [7:0] NCELLS   = 8'(COLS * ROWS);
  localparam logic [3:0] NROWS    = 4'(ROWS);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'(COLS - 1);

  state_t      state;
  logic [3:0]  wr_row;
  logic [3:0]  wr_col;
  logic        accept;
  logic        conv_done;
  logic [15:0] conv_bcd;
  logic        we;
  logic [7:0]  wa;
  logic [6:0]  wd;
  logic [6:0]  mem [0:COLS*ROWS-1];

  // Out-of-range channels are accepted by the handshake but never start an update.
  assign accept = (state == ST_IDLE) && meas_ready && meas_valid && (meas_ch < NROWS);

  // A 12-bit input tops out at 4095 mV, so the 9999 mV display ceiling is never
  // reached and four BCD digits always suffice without a clamp stage.
  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .bin   (meas_data),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  assign we = (state == ST_INIT) || (state == ST_WRITE);
  assign wa = 8'(wr_row) * 8'(COLS) + 8'(wr_col);
  assign wd = cell_char(wr_row, wr_col, (state == ST_WRITE) ? conv_bcd : 16'h0000);

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Read-first: the write above lands in the same NBA slot as this read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  char_code <= ASCII_SPACE;
    else if (text_xy < NCELLS) char_code <= mem[text_xy];
    else                      char_code <= ASCII_SPACE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT;
      meas_ready <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (wr_col == LAST_COL) begin
            wr_col <= '0;
            if (wr_row == LAST_ROW) begin
              wr_row     <= '0;
              state      <= ST_IDLE;
              meas_ready <= 1'b1;
            end else begin
              wr_row <= wr_row + 4'd1;
            end
          end else begin
            wr_col <= wr_col + 4'd1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            wr_row     <= meas_ch;
            wr_col     <= '0;
            state      <= ST_CONVERT;
            meas_ready <= 1'b0;
          end
        end
        ST_CONVERT: begin
          if (conv_done) state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (wr_col == LAST_COL) begin
            wr_col     <= '0;
            state      <= ST_IDLE;
            meas_ready <= 1'b1;
          end else begin
            wr_col <= wr_col + 4'd1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_buffer.sv
// Randomized self-checking bench for vga_text_buffer against a row-text model.
module tb_vga_text_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] meas_data;
  logic [3:0]  meas_ch;
  logic        meas_valid;
  logic        meas_ready;
  logic [7:0]  text_xy;
  logic [6:0]  char_code;

  int n_checks = 0;
  int n_errors = 0;
  int row_mv [13];
  int cyc = 0;
  bit mon_on = 0;
  int acc_q [$];

  vga_text_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .meas_data  (meas_data),
    .meas_ch    (meas_ch),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .text_xy    (text_xy),
    .char_code  (char_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_on && !rst && meas_valid && meas_ready) acc_q.push_back(cyc);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int exp_char(input int a);
    string s;
    int r;
    if (a >= 156) return 32;
    r = a / 12;
    s = $sformatf("CH%02d %0d.%03dV ", r, row_mv[r] / 1000, row_mv[r] % 1000);
    return int'(s[a % 12]);
  endfunction

  task automatic read_cell(input int a, output int c);
    text_xy = 8'(a);
    @(posedge clk); #1;
    c = int'(char_code);
  endtask

  task automatic check_row(input int r);
    int c;
    for (int k = 0; k < 12; k++) begin
      read_cell(r * 12 + k, c);
      check($sformatf("row%0d_col%0d", r, k), c, exp_char(r * 12 + k));
    end
  endtask

  task automatic check_row_str(input int r, input string s);
    int c;
    for (int k = 0; k < 12; k++) begin
      read_cell(r * 12 + k, c);
      check($sformatf("text_row%0d_col%0d", r, k), c, int'(s[k]));
    end
  endtask

  task automatic check_all();
    for (int r = 0; r < 13; r++) check_row(r);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!meas_ready && n < 400);
  endtask

  // Presents one measurement for a single edge; returns cycles meas_ready stayed low.
  task automatic send(input int ch, input int data, input int peek_addr,
                      input int old_c, input int new_c, output int low);
    meas_ch    = 4'(ch);
    meas_data  = 12'(data);
    meas_valid = 1'b1;
    @(posedge clk); #1;
    meas_valid = 1'b0;
    low = 0;
    while (!meas_ready && low < 100) begin
      low++;
      if (peek_addr >= 0) begin
        if (low == 18) text_xy = 8'(peek_addr);
        if (low == 19) check("read_first_old", int'(char_code), old_c);
        if (low == 20) check("read_first_new", int'(char_code), new_c);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n, low, c, ch, data, old_c, new_c;
    rst = 1'b1; meas_valid = 1'b0; meas_ch = '0; meas_data = '0; text_xy = '0;
    for (int r = 0; r < 13; r++) row_mv[r] = 0;

    repeat (3) @(posedge clk); #1;
    check("rst_ready", int'(meas_ready), 0);
    check("rst_char", int'(char_code), 32);
    rst = 1'b0;
    wait_init(n);
    check("init_cycles", n, 156);
    check_row_str(0, "CH00 0.000V ");
    check_all();

    // ch3 = 1234 with a read of the d3 cell on the very edge it is rewritten
    old_c = exp_char(3 * 12 + 5);
    row_mv[3] = 1234;
    new_c = exp_char(3 * 12 + 5);
    send(3, 1234, 3 * 12 + 5, old_c, new_c, low);
    check("busy_ch3", low, 24);
    check_row_str(3, "CH03 1.234V ");
    check_row(2);

    send(12, 4000, -1, 0, 0, low);
    row_mv[12] = 4000;
    check("busy_ch12a", low, 24);
    check_row_str(12, "CH12 4.000V ");
    send(12, 4095, -1, 0, 0, low);
    row_mv[12] = 4095;
    check("busy_ch12b", low, 24);
    check_row_str(12, "CH12 4.095V ");

    send(13, 500, -1, 0, 0, low);
    check("drop_busy", low, 0);
    check("drop_ready", int'(meas_ready), 1);
    check_all();

    // valid held high across three values: one accept every 25 cycles
    acc_q.delete();
    mon_on = 1;
    meas_ch = 4'd7; meas_data = 12'd111; meas_valid = 1'b1;
    @(posedge clk); #1;
    meas_data = 12'd2222;
    repeat (25) @(posedge clk); #1;
    meas_data = 12'd3333;
    repeat (25) @(posedge clk); #1;
    meas_valid = 1'b0;
    n = 0;
    while (!meas_ready && n < 100) begin @(posedge clk); #1; n++; end
    mon_on = 0;
    check("hold_accepts", acc_q.size(), 3);
    if (acc_q.size() >= 3) begin
      check("hold_gap1", acc_q[1] - acc_q[0], 25);
      check("hold_gap2", acc_q[2] - acc_q[1], 25);
    end
    row_mv[7] = 3333;
    check_row_str(7, "CH07 3.333V ");

    for (int i = 0; i < 10; i++) begin
      ch = int'($urandom_range(0, 15));
      data = (i == 0) ? 0 : (i == 1) ? 4095 : int'($urandom_range(0, 4095));
      send(ch, data, -1, 0, 0, low);
      if (ch < 13) begin
        row_mv[ch] = data;
        check($sformatf("rand_busy%0d", i), low, 24);
        check_row(ch);
      end else begin
        check($sformatf("rand_drop%0d", i), low, 0);
      end
      read_cell(int'($urandom_range(156, 255)), c);
      check($sformatf("rand_oob%0d", i), c, 32);
    end
    check_all();

    // reset in the middle of rewriting row 5
    meas_ch = 4'd5; meas_data = 12'd777; meas_valid = 1'b1;
    @(posedge clk); #1;
    meas_valid = 1'b0;
    repeat (16) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", int'(meas_ready), 0);
    check("midrst_char", int'(char_code), 32);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int r = 0; r < 13; r++) row_mv[r] = 0;
    wait_init(n);
    check("reinit_cycles", n, 156);
    check_row_str(5, "CH05 0.000V ");
    check_all();
    read_cell(200, c);
    check("oob_200", c, 32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_text_buffer.md
VGA_TEXT_BUFFER -- requirements
Module: vga_text_buffer

Interface
REQ-001 SHALL have parameter COLS, default 12, meaning characters per text row.
REQ-002 SHALL have parameter ROWS, default 13, meaning text rows, one per measurement channel.
REQ-003 SHALL have port clk  input  1  meaning the single clock for all logic.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port meas_data  input  12  meaning channel voltage in mV, unsigned.
REQ-006 SHALL have port meas_ch  input  4  meaning channel index 0..ROWS-1.
REQ-007 SHALL have port meas_valid  input  1  meaning meas_data/meas_ch are valid.
REQ-008 SHALL have port meas_ready  output  1  meaning the block can accept a measurement.
REQ-009 SHALL have port text_xy  input  8  meaning character cell address from the character renderer, row*COLS+col.
REQ-010 SHALL have port char_code  output  7  meaning ASCII code of the addressed cell.

Function
REQ-011 SHALL hold a ROWS*COLS (156) entry x 7-bit character RAM with one write port and one read port.
REQ-012 SHALL register char_code one clk after text_xy, giving 1-cycle latency.
REQ-013 SHALL return 0x20 (space) for text_xy >= ROWS*COLS.
REQ-014 SHALL give read-first behaviour: a read of an address written in the same cycle returns the old content.
REQ-015 SHALL lay out row r (channel r) as 'C','H',tens(r),units(r),' ',d3,'.',d2,d1,d0,'V',' ', where d3..d0 are decimal digits of mV.
REQ-016 SHALL implement FSM states INIT, IDLE, CONVERT, WRITE.
REQ-017 INIT SHALL write the template for every row, with digits "0.000", at one cell per cycle, addresses 0..155 ascending, for 156 cycles, then go to IDLE.
REQ-018 IDLE SHALL drive meas_ready=1; all other states SHALL drive meas_ready=0.
REQ-019 A transfer SHALL occur on a clk edge with meas_valid=1 and meas_ready=1; the block SHALL capture data and channel and enter CONVERT.
REQ-020 CONVERT SHALL run a sequential double-dabble conversion of 12 iterations, one per cycle, then enter WRITE.
REQ-021 meas_data > 9999 SHALL saturate to 9999 before conversion.
REQ-022 WRITE SHALL write the 12 cells of row meas_ch, columns 0..11 ascending, one per cycle, then return to IDLE.
REQ-023 meas_ready SHALL be low for exactly 24 cycles after an accepting edge (12 CONVERT + 12 WRITE).
REQ-024 meas_ch >= ROWS SHALL be accepted and dropped: no RAM write, state stays IDLE, meas_ready stays 1.
REQ-025 meas_valid while meas_ready=0 SHALL be ignored, with no buffering.
REQ-026 Reads SHALL continue uninterrupted in every state.

Reset
REQ-027 On rst=1 the block SHALL asynchronously force state=INIT, meas_ready=0, char_code=0x20, conversion registers=0, and the write counter=0.
REQ-028 RAM content SHALL NOT be reset; INIT SHALL rewrite it fully after rst deasserts.
REQ-029 rst during CONVERT or WRITE SHALL abandon the update; the row SHALL be restored by INIT.

Structure
REQ-030 Package vga_text_pkg SHALL hold COLS, ROWS, ASCII constants (space, 'C', 'H', '.', 'V', '0') and the FSM state encoding.
REQ-031 The double-dabble converter SHALL be a sub-module bin2bcd_seq (start, 12-bit in, 16-bit BCD out, done).
REQ-032 The RAM SHALL be inferable as a single block/distributed RAM with no reset on its array.

Verification
REQ-033 Release rst, wait -> meas_ready=0 for 156 cycles then 1; text_xy=0..11 reads "CH00 0.000V ".
REQ-034 Send ch=3, data=1234 -> 24 cycles with meas_ready=0; then text_xy=36..47 reads "CH03 1.234V ", and row 2 is unchanged.
REQ-035 Send ch=12, data=4000 -> row 12 reads "CH12 4.000V "; send data=4095 -> "CH12 4.095V "; force data=12'hFFF -> no overflow.
REQ-036 Send ch=13, data=500 -> no cell changes, meas_ready stays 1.
REQ-037 Hold meas_valid high continuously with 3 values -> exactly one accept per 25-cycle window, and the last value is displayed.
REQ-038 Assert rst mid-WRITE of ch=5 -> after INIT, row 5 reads "CH05 0.000V "; text_xy=200 -> char_code=0x20.
